fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the combinational instruction ROM.
- Holds the PC and drives the ROM byte address every cycle.
- Captures the returned 32-bit instruction with its PC into a small FIFO, then presents entries to decode over a valid/ready handshake.
- Handles back-end redirects (branch resolution, flush) and stops fetching at the end of instruction memory.

---
 rtl/fetch_queue.sv | 67 ++++++
 tb/tb_fetch_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC/ROM fetch into a valid/ready instruction FIFO; define FETCH_PREDECODE_EN to follow unconditional B targets at fetch
module fetch_queue #(
  parameter int          QUEUE_DEPTH       = 4,
  parameter logic [63:0] RESET_PC          = 64'd0,
  parameter int          INSTRUCT_MEM_SIZE = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [63:0]                    imem_address,
  input  logic [31:0]                    imem_instruction,
  input  logic                           redirect_valid,
  input  logic [63:0]                    redirect_pc,
  output logic                           dec_valid,
  input  logic                           dec_ready,
  output logic [31:0]                    dec_instruction,
  output logic [63:0]                    dec_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           fetch_halted
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  logic [63:0]   pc_q, pc_d, next_pc;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [95:0]   entry_q [QUEUE_DEPTH];
  logic          push, pop;
  assign imem_address = pc_q;
  assign queue_count  = count_q;
  assign fetch_halted = pc_q + 64'd3 >= 64'(INSTRUCT_MEM_SIZE);
  assign dec_valid    = count_q != '0;
  assign {dec_pc, dec_instruction} = dec_valid ? entry_q[head_q] : 96'd0;
  assign push = !redirect_valid && count_q < CW'(QUEUE_DEPTH) && !fetch_halted;
  assign pop  = dec_valid && dec_ready && !redirect_valid;
`ifdef FETCH_PREDECODE_EN
  assign next_pc = imem_instruction[31:26] == 6'b000101
                 ? pc_q + {{36{imem_instruction[25]}}, imem_instruction[25:0], 2'b00}
                 : pc_q + 64'd4;
`else
  assign next_pc = pc_q + 64'd4;
`endif
  always_comb begin
    pc_d    = redirect_valid ? {redirect_pc[63:2], 2'b00} : push ? next_pc : pc_q;
    head_d  = redirect_valid ? '0 : pop ? head_q + PW'(1) : head_q;
    tail_d  = redirect_valid ? '0 : push ? tail_q + PW'(1) : tail_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) entry_q[tail_q] <= {pc_q, imem_instruction};
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_q <= CW'(QUEUE_DEPTH));
      assert (imem_address[1:0] == 2'b00);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized fetch_queue bench against a queue-based reference model
module tb_fetch_queue;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } entry_t;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instruction;
  logic [63:0] dec_pc;
  logic [2:0]  queue_count;
  logic        fetch_halted;
  int          vectors = 0;
  int          miscompares = 0;
  logic        b_mode = 1'b0;
  entry_t      mq[$];
  logic [63:0] mpc;
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .imem_address(imem_address),
    .imem_instruction(imem_instruction), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instruction(dec_instruction), .dec_pc(dec_pc),
    .queue_count(queue_count), .fetch_halted(fetch_halted)
  );
  function automatic logic [31:0] rom(input logic [63:0] a);
    return (b_mode && a == 64'd8) ? 32'h1400_0004 : a[31:0];
  endfunction
  always_comb imem_instruction = rom(imem_address);
  function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] ins);
    longint off;
    off = 4;
`ifdef FETCH_PREDECODE_EN
    if (ins[31:26] == 6'b000101) off = 4 * longint'($signed(ins[25:0]));
`endif
    return pc + 64'(off);
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic rv, input logic [63:0] rpc, input logic rdy);
    bit halted, push, pop;
    reset_n = rn;
    redirect_valid = rv;
    redirect_pc = rpc;
    dec_ready = rdy;
    @(negedge clk);
    halted = mpc + 64'd3 >= 64'd1024;
    check("imem_address", imem_address, mpc);
    check("fetch_halted", 64'(fetch_halted), 64'(halted));
    check("queue_count", 64'(queue_count), 64'(mq.size()));
    check("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
    check("dec_pc", dec_pc, mq.size() != 0 ? mq[0].pc : 64'd0);
    check("dec_instruction", 64'(dec_instruction), mq.size() != 0 ? 64'(mq[0].ins) : 64'd0);
    if (!rn) begin
      mq.delete();
      mpc = 64'd0;
    end else if (rv) begin
      mq.delete();
      mpc = rpc & ~64'd3;
    end else begin
      push = mq.size() < 4 && !halted;
      pop = mq.size() != 0 && rdy;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: mpc, ins: rom(mpc)});
        mpc = model_next(mpc, rom(mpc));
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mpc = 64'd0;
    step(1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0, 1'b1);
    check("stream_pc", dec_pc, 64'd20);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    check("sat_count", 64'(queue_count), 64'd4);
    check("sat_addr", imem_address, 64'd36);
    check("sat_head", dec_pc, 64'd20);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 64'h43, 1'b0);
    check("redir_count", 64'(queue_count), 64'd0);
    check("redir_valid", 64'(dec_valid), 64'd0);
    check("redir_addr", imem_address, 64'h40);
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("redir_pc", dec_pc, 64'h40);
    step(1'b1, 1'b1, 64'd1016, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'd0, 1'b1);
    check("halt_flag", 64'(fetch_halted), 64'd1);
    check("halt_addr", imem_address, 64'd1024);
    step(1'b1, 1'b1, 64'd0, 1'b1);
    check("unhalt_flag", 64'(fetch_halted), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    check("rst_count", 64'(queue_count), 64'd0);
    check("rst_addr", imem_address, 64'd0);
    b_mode = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic rn, rv;
      logic [63:0] rpc;
      rn = $urandom_range(0, 49) != 0;
      rv = $urandom_range(0, 19) == 0;
      rpc = $urandom_range(0, 3) == 0 ? 64'($urandom_range(1000, 1030)) : 64'($urandom_range(0, 1100));
      step(rn, rv, rpc, 1'($urandom_range(0, 3) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
